// File: rtl/riscv_pkg.sv
// Constants shared by decode, fetch and the register file.
// Holds architectural widths, the zero register and the PC defaults.
package riscv_pkg;

   localparam int          XLEN         = 32;
   localparam logic [4:0]  REG_ZERO     = 5'd0;
   localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
   localparam int          PC_STEP_DEF  = 4;

endpackage

// File: rtl/pc_counter.sv
// Program counter register.
// Branch load beats stall, which beats the sequential increment.
module pc_counter
   import riscv_pkg::*;
#(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter int              PC_STEP  = PC_STEP_DEF,
   parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_VEC)
) (
   input  logic            CK_REF,
   input  logic            RST_N,
   input  logic            PC_STALL,
   input  logic            PC_LOAD,
   input  logic [XLEN-1:0] PC_LOAD_VAL,
   output logic [XLEN-1:0] PC_OUT
);

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   always_ff @(posedge CK_REF or negedge RST_N) begin
      if (!RST_N) begin
         PC_OUT <= PC_RESET;
      end else if (PC_LOAD) begin
         // Targets are word aligned; the low bits are dropped.
         PC_OUT <= {PC_LOAD_VAL[XLEN-1:2], 2'b00};
      end else if (!PC_STALL) begin
         PC_OUT <= PC_OUT + STEP;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR file with write-through read ports, a pending-write scoreboard
// and the fetch program counter.
module regfile_scoreboard
   import riscv_pkg::*;
#(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter int              NUM_REGS = 32,
   parameter int              ADDR_W   = $clog2(NUM_REGS),
   parameter int              NUM_RD   = 2,
   parameter int              BYPASS   = 1,
   parameter int              PC_STEP  = PC_STEP_DEF,
   parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_VEC)
) (
   input  logic                     CK_REF,
   input  logic                     RST_N,
   input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
   output logic [NUM_RD*XLEN-1:0]   RD_DATA,
   output logic [NUM_RD-1:0]        RD_BUSY,
   input  logic                     WR_EN,
   input  logic [ADDR_W-1:0]        WR_ADDR,
   input  logic [XLEN-1:0]          WR_DATA,
   input  logic                     ISSUE_EN,
   input  logic [ADDR_W-1:0]        ISSUE_RD,
   input  logic                     PC_STALL,
   input  logic                     PC_LOAD,
   input  logic [XLEN-1:0]          PC_LOAD_VAL,
   output logic [XLEN-1:0]          PC_OUT
);

   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic [XLEN-1:0]     gpr [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic                wr_ok;
   logic                iss_ok;

   assign wr_ok  = WR_EN && (WR_ADDR != ZERO);
   assign iss_ok = ISSUE_EN && (ISSUE_RD != ZERO);

   // Issue is applied last so a new producer outlives a same-cycle writeback.
   always_ff @(posedge CK_REF or negedge RST_N) begin
      if (!RST_N) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            gpr[r] <= '0;
         end
         busy <= '0;
      end else begin
         if (wr_ok) begin
            gpr[WR_ADDR]  <= WR_DATA;
            busy[WR_ADDR] <= 1'b0;
         end
         if (iss_ok) begin
            busy[ISSUE_RD] <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit;
      logic              nz;

      assign addr = RD_ADDR[i*ADDR_W +: ADDR_W];
      assign nz   = (addr != ZERO);
      assign hit  = (BYPASS != 0) && RST_N && wr_ok && (WR_ADDR == addr);

      assign RD_DATA[i*XLEN +: XLEN] = !nz ? '0 :
                                       hit ? WR_DATA : gpr[addr];
      assign RD_BUSY[i] = nz && !hit && busy[addr];
   end

   pc_counter #(
      .XLEN     (XLEN),
      .PC_STEP  (PC_STEP),
      .PC_RESET (PC_RESET)
   ) u_pc (
      .CK_REF      (CK_REF),
      .RST_N       (RST_N),
      .PC_STALL    (PC_STALL),
      .PC_LOAD     (PC_LOAD),
      .PC_LOAD_VAL (PC_LOAD_VAL),
      .PC_OUT      (PC_OUT)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random and directed checks of the register file against an array model.
// Second instance covers the 4-port, 16-register, no-bypass build.
module tb_regfile_scoreboard;

   logic ck = 1'b0;
   logic rst_n = 1'b0;
   always #5 ck = ~ck;

   int n_chk = 0;
   int n_err = 0;

   // main build: 32 regs, 2 ports, bypass on
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        pc_stall;
   logic        pc_load;
   logic [31:0] pc_load_val;
   logic [31:0] pc_out;

   // small build: 16 regs, 4 ports, bypass off
   logic [15:0]  rd2_addr;
   logic [127:0] rd2_data;
   logic [3:0]   rd2_busy;
   logic         wr2_en;
   logic [3:0]   wr2_addr;
   logic [31:0]  wr2_data;
   logic         issue2_en;
   logic [3:0]   issue2_rd;
   logic [31:0]  pc2_out;

   regfile_scoreboard dut (
      .CK_REF      (ck),
      .RST_N       (rst_n),
      .RD_ADDR     (rd_addr),
      .RD_DATA     (rd_data),
      .RD_BUSY     (rd_busy),
      .WR_EN       (wr_en),
      .WR_ADDR     (wr_addr),
      .WR_DATA     (wr_data),
      .ISSUE_EN    (issue_en),
      .ISSUE_RD    (issue_rd),
      .PC_STALL    (pc_stall),
      .PC_LOAD     (pc_load),
      .PC_LOAD_VAL (pc_load_val),
      .PC_OUT      (pc_out)
   );

   regfile_scoreboard #(
      .NUM_REGS (16),
      .NUM_RD   (4),
      .BYPASS   (0)
   ) dut2 (
      .CK_REF      (ck),
      .RST_N       (rst_n),
      .RD_ADDR     (rd2_addr),
      .RD_DATA     (rd2_data),
      .RD_BUSY     (rd2_busy),
      .WR_EN       (wr2_en),
      .WR_ADDR     (wr2_addr),
      .WR_DATA     (wr2_data),
      .ISSUE_EN    (issue2_en),
      .ISSUE_RD    (issue2_rd),
      .PC_STALL    (pc_stall),
      .PC_LOAD     (pc_load),
      .PC_LOAD_VAL (pc_load_val),
      .PC_OUT      (pc2_out)
   );

   logic [31:0] m_reg [32];
   bit          m_busy [32];
   logic [31:0] m_pc;
   logic [31:0] m2_reg [16];
   bit          m2_busy [16];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_reg[r] = '0;
         m_busy[r] = 0;
      end
      for (int r = 0; r < 16; r++) begin
         m2_reg[r] = '0;
         m2_busy[r] = 0;
      end
      m_pc = '0;
   endtask

   // Expected read value: x0 is zero, bypass shows the write in flight.
   function automatic logic [31:0] exp_data(input int a);
      if (a == 0) return 0;
      if (rst_n && wr_en && wr_addr == a) return wr_data;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input int a);
      if (a == 0) return 0;
      if (rst_n && wr_en && wr_addr == a) return 0;
      return m_busy[a];
   endfunction

   task automatic check_all();
      int a;
      #1;
      for (int i = 0; i < 2; i++) begin
         a = int'(rd_addr[i*5 +: 5]);
         chk("rd_data", {32'h0, rd_data[i*32 +: 32]}, {32'h0, exp_data(a)});
         chk("rd_busy", {63'h0, rd_busy[i]}, {63'h0, exp_busy(a)});
      end
      for (int i = 0; i < 4; i++) begin
         a = int'(rd2_addr[i*4 +: 4]);
         chk("rd2_data", {32'h0, rd2_data[i*32 +: 32]},
             {32'h0, (a == 0) ? 32'h0 : m2_reg[a]});
         chk("rd2_busy", {63'h0, rd2_busy[i]},
             {63'h0, (a != 0) && m2_busy[a]});
      end
      chk("pc", {32'h0, pc_out}, {32'h0, m_pc});
      chk("pc2", {32'h0, pc2_out}, {32'h0, m_pc});
   endtask

   task automatic tick();
      @(posedge ck);
      if (rst_n) begin
         if (wr_en && wr_addr != 0) begin
            m_reg[wr_addr] = wr_data;
            m_busy[wr_addr] = 0;
         end
         if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
         if (wr2_en && wr2_addr != 0) begin
            m2_reg[wr2_addr] = wr2_data;
            m2_busy[wr2_addr] = 0;
         end
         if (issue2_en && issue2_rd != 0) m2_busy[issue2_rd] = 1;
         if (pc_load) m_pc = pc_load_val & 32'hFFFF_FFFC;
         else if (!pc_stall) m_pc = m_pc + 32'd4;
      end
      @(negedge ck);
   endtask

   task automatic idle();
      wr_en = 0;
      issue_en = 0;
      wr2_en = 0;
      issue2_en = 0;
      pc_stall = 0;
      pc_load = 0;
   endtask

   initial begin
      rd_addr = '0;
      wr_addr = '0;
      wr_data = '0;
      issue_rd = '0;
      pc_load_val = '0;
      rd2_addr = '0;
      wr2_addr = '0;
      wr2_data = '0;
      issue2_rd = '0;
      idle();
      model_reset();
      check_all();
      chk("rst_pc", {32'h0, pc_out}, 64'h0);
      tick();
      rst_n = 1'b1;

      // PC sequencing
      tick();
      chk("pc_run4", {32'h0, pc_out}, 64'd4);
      tick();
      tick();
      chk("pc_run12", {32'h0, pc_out}, 64'd12);
      pc_stall = 1;
      tick();
      tick();
      chk("pc_stall", {32'h0, pc_out}, 64'd12);
      pc_load = 1;
      pc_load_val = 32'h103;
      tick();
      chk("pc_load", {32'h0, pc_out}, 64'h100);
      pc_stall = 0;
      pc_load_val = 32'hFFFF_FFFC;
      tick();
      pc_load = 0;
      tick();
      chk("pc_wrap", {32'h0, pc_out}, 64'h0);
      pc_stall = 1;

      // write and x0
      wr_en = 1;
      wr_addr = 5;
      wr_data = 32'hDEAD_BEEF;
      tick();
      wr_en = 0;
      rd_addr = {5'd0, 5'd5};
      check_all();
      chk("wr_x5", {32'h0, rd_data[31:0]}, 64'hDEAD_BEEF);
      wr_en = 1;
      wr_addr = 0;
      wr_data = 32'h1234;
      tick();
      wr_en = 0;
      rd_addr = {5'd0, 5'd0};
      check_all();
      chk("wr_x0", {32'h0, rd_data[31:0]}, 64'h0);

      // bypass with a pending producer on x7
      issue_en = 1;
      issue_rd = 7;
      tick();
      issue_en = 0;
      rd_addr = {5'd7, 5'd0};
      check_all();
      chk("busy_x7", {63'h0, rd_busy[1]}, 64'h1);
      wr_en = 1;
      wr_addr = 7;
      wr_data = 32'hA5A5_A5A5;
      check_all();
      chk("byp_data", {32'h0, rd_data[63:32]}, 64'hA5A5_A5A5);
      chk("byp_busy", {63'h0, rd_busy[1]}, 64'h0);
      tick();
      idle();
      pc_stall = 1;

      // scoreboard set/clear/race
      issue_en = 1;
      issue_rd = 3;
      tick();
      issue_en = 0;
      rd_addr = {5'd0, 5'd3};
      check_all();
      chk("sb_set", {63'h0, rd_busy[0]}, 64'h1);
      wr_en = 1;
      wr_addr = 3;
      wr_data = 32'h1111_0000;
      tick();
      wr_en = 0;
      check_all();
      chk("sb_clr", {63'h0, rd_busy[0]}, 64'h0);
      issue_en = 1;
      wr_en = 1;
      wr_data = 32'h0000_0055;
      tick();
      idle();
      pc_stall = 1;
      check_all();
      chk("sb_race_busy", {63'h0, rd_busy[0]}, 64'h1);
      chk("sb_race_data", {32'h0, rd_data[31:0]}, 64'h55);
      issue_en = 1;
      issue_rd = 0;
      tick();
      issue_en = 0;
      rd_addr = {5'd0, 5'd0};
      check_all();
      chk("sb_x0", {63'h0, rd_busy[0]}, 64'h0);

      // 4-port build: x1..x4, no bypass
      for (int r = 1; r <= 4; r++) begin
         wr2_en = 1;
         wr2_addr = 4'(r);
         wr2_data = 32'h100 * r + 32'h7;
         tick();
      end
      wr2_en = 0;
      rd2_addr = {4'd4, 4'd3, 4'd2, 4'd1};
      check_all();
      chk("p4_x1", {32'h0, rd2_data[31:0]}, 64'h107);
      chk("p4_x4", {32'h0, rd2_data[127:96]}, 64'h407);
      wr2_en = 1;
      wr2_addr = 4;
      wr2_data = 32'hCAFE_0004;
      check_all();
      chk("nobyp_old", {32'h0, rd2_data[127:96]}, 64'h407);
      tick();
      wr2_en = 0;
      check_all();
      chk("nobyp_new", {32'h0, rd2_data[127:96]}, 64'hCAFE_0004);
      rd2_addr = {4'd0, 4'd0, 4'd0, 4'd0};
      check_all();
      chk("p4_x0", {32'h0, rd2_data[31:0]}, 64'h0);

      // randomized traffic with a reset mid-run
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            rd_addr[i*5 +: 5] = ($urandom_range(0, 3) == 0) ?
                                5'($urandom) : 5'($urandom_range(0, 7));
         end
         rd2_addr = 16'($urandom) & 16'h7777;
         wr_en = 1'($urandom);
         wr_addr = 5'($urandom_range(0, 7));
         wr_data = $urandom;
         issue_en = 1'($urandom);
         issue_rd = 5'($urandom_range(0, 7));
         wr2_en = 1'($urandom);
         wr2_addr = 4'($urandom_range(0, 7));
         wr2_data = $urandom;
         issue2_en = 1'($urandom);
         issue2_rd = 4'($urandom_range(0, 7));
         pc_stall = ($urandom_range(0, 3) == 0);
         pc_load = ($urandom_range(0, 15) == 0);
         pc_load_val = $urandom;
         if (n == 200) begin
            rst_n = 1'b0;
            model_reset();
            check_all();
            chk("rst_mid_pc", {32'h0, pc_out}, 64'h0);
            chk("rst_mid_busy", {60'h0, rd2_busy}, 64'h0);
            tick();
            rst_n = 1'b1;
         end else begin
            check_all();
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
